// File: rtl/ps2_note_pkg.sv
// -----------------------------------------------------------------------------
// ps2_note_pkg
// Shared types and constants for the PS/2 note receiver:
//   - frame_state_t : PS/2 frame FSM states
//   - SC_*          : scan codes for prefixes and the eight note keys
//   - FREQ_*        : note frequencies in Hz
//   - scan_to_freq  : scan code -> frequency in Hz, 0 for unmapped codes
// -----------------------------------------------------------------------------
package ps2_note_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Width of the frequency constants; large enough for the top note (523 Hz).
    localparam int NOTE_W = 10;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_C4 = 8'h1C;
    localparam logic [7:0] SC_D4 = 8'h1B;
    localparam logic [7:0] SC_E4 = 8'h23;
    localparam logic [7:0] SC_F4 = 8'h2B;
    localparam logic [7:0] SC_G4 = 8'h34;
    localparam logic [7:0] SC_A4 = 8'h33;
    localparam logic [7:0] SC_B4 = 8'h3B;
    localparam logic [7:0] SC_C5 = 8'h42;

    localparam logic [NOTE_W-1:0] FREQ_C4 = 10'd261;
    localparam logic [NOTE_W-1:0] FREQ_D4 = 10'd293;
    localparam logic [NOTE_W-1:0] FREQ_E4 = 10'd329;
    localparam logic [NOTE_W-1:0] FREQ_F4 = 10'd349;
    localparam logic [NOTE_W-1:0] FREQ_G4 = 10'd392;
    localparam logic [NOTE_W-1:0] FREQ_A4 = 10'd440;
    localparam logic [NOTE_W-1:0] FREQ_B4 = 10'd493;
    localparam logic [NOTE_W-1:0] FREQ_C5 = 10'd523;

    function automatic logic [NOTE_W-1:0] scan_to_freq(input logic [7:0] code);
        case (code)
            SC_C4:   return FREQ_C4;
            SC_D4:   return FREQ_D4;
            SC_E4:   return FREQ_E4;
            SC_F4:   return FREQ_F4;
            SC_G4:   return FREQ_G4;
            SC_A4:   return FREQ_A4;
            SC_B4:   return FREQ_B4;
            SC_C5:   return FREQ_C5;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// -----------------------------------------------------------------------------
// ps2_frame_rx
// Synchronises the raw PS/2 lines, detects falling edges of the PS/2 clock and
// decodes 11-bit frames (start, 8 data LSB-first, parity, stop) with timeout.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_data raw asynchronous PS/2 lines
//   byte_valid        one-cycle pulse, byte_data holds an accepted byte
//   byte_data         last accepted byte
//   frame_err         one-cycle pulse on bad parity, bad stop bit or timeout
//
// Build option: PS2_PARITY_CHECK_EN enforces odd parity; otherwise the parity
// bit is consumed but not checked.
// -----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_note_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fe;
    logic                   data_q;

    frame_state_t state, state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic [TW-1:0] tcount;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q;
`endif

    logic shift_en;
    logic accept;
    logic err;
    logic timeout;
    logic parity_good;

    // fe is registered so it appears SYNC_STAGES+1 cycles after the raw fall;
    // data_q is registered alongside it so both refer to the same instant.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fe        <= 1'b0;
            data_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fe        <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            data_q    <= data_sync[SYNC_STAGES-1];
        end
    end

    assign timeout = (state != IDLE) && !fe && (tcount == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data bits plus parity bit carry an odd number of ones.
    assign parity_good = ^{shift_q, parity_q};
`else
    assign parity_good = 1'b1;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        accept     = 1'b0;
        err        = 1'b0;
        if (timeout) begin
            state_next = IDLE;
            err        = 1'b1;
        end else if (fe) begin
            case (state)
                IDLE:   if (!data_q) state_next = DATA;
                DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end
                PARITY: state_next = STOP;
                STOP: begin
                    if (data_q && parity_good) accept = 1'b1;
                    else                       err    = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            tcount     <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            byte_valid <= accept;
            frame_err  <= err;

            if (state == IDLE || fe || timeout) tcount <= '0;
            else                                tcount <= tcount + 1'b1;

            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_q <= {data_q, shift_q[7:1]};
            if (accept)   byte_data <= shift_q;
`ifdef PS2_PARITY_CHECK_EN
            if (fe && state == PARITY) parity_q <= data_q;
`endif
        end
    end

endmodule

// File: rtl/ps2_note_receiver.sv
// -----------------------------------------------------------------------------
// ps2_note_receiver
// PS/2 keyboard front end: frame reception (ps2_frame_rx), make/break/extended
// interpretation and a polyphonic table of held notes.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   ps2_clk       raw PS/2 clock line
//   ps2_data      raw PS/2 data line
//   voice_freq    per-voice frequency, voice i at [i*FREQ_W +: FREQ_W], 0 idle
//   voice_active  per-voice held flag
//   note_valid    one-cycle strobe on every voice-table change
//   note_on       1 = key pressed, 0 = released (qualified by note_valid)
//   note_freq     frequency of the changed note (qualified by note_valid)
//   frame_err     one-cycle pulse on a frame error
//
// Build option: PS2_PARITY_CHECK_EN (see ps2_frame_rx).
// -----------------------------------------------------------------------------
module ps2_note_receiver
    import ps2_note_pkg::*;
#(
    parameter int NUM_VOICES     = 4,
    parameter int FREQ_W         = 10,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         note_valid,
    output logic                         note_on,
    output logic [FREQ_W-1:0]            note_freq,
    output logic                         frame_err
);

    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic       byte_valid;
    logic [7:0] byte_data;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_frame_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    logic              brk;
    logic              ext;
    logic [FREQ_W-1:0] vfreq [NUM_VOICES];

    logic [FREQ_W-1:0] byte_freq;
    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic              free;
    logic [IW-1:0]     free_idx;

    assign byte_freq = FREQ_W'(scan_to_freq(byte_data));

    // Descending scans so the lowest matching / idle index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && vfreq[i] == byte_freq) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!voice_active[i]) begin
                free     = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        voice_freq = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            voice_freq[i*FREQ_W +: FREQ_W] = vfreq[i];
    end

    // NOTE: the voice table is a handful of registers that must read as idle
    // after reset, so it is reset explicitly rather than left as RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            brk          <= 1'b0;
            ext          <= 1'b0;
            voice_active <= '0;
            note_valid   <= 1'b0;
            note_on      <= 1'b0;
            note_freq    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) vfreq[i] <= '0;
        end else begin
            note_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_data == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (byte_data == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!ext && byte_freq != '0) begin
                        if (!brk) begin
                            // Typematic repeats of a held note and a full
                            // table both leave everything untouched.
                            if (!hit && free) begin
                                vfreq[free_idx]        <= byte_freq;
                                voice_active[free_idx] <= 1'b1;
                                note_valid             <= 1'b1;
                                note_on                <= 1'b1;
                                note_freq              <= byte_freq;
                            end
                        end else if (hit) begin
                            vfreq[hit_idx]        <= '0;
                            voice_active[hit_idx] <= 1'b0;
                            note_valid            <= 1'b1;
                            note_on               <= 1'b0;
                            note_freq             <= byte_freq;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_note_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_note_receiver
// Directed bench for ps2_note_receiver: drives PS/2 frames bit by bit and
// compares the voice table, strobes and error pulses with hand-derived values.
// -----------------------------------------------------------------------------
module tb_ps2_note_receiver;

    localparam int NV   = 4;
    localparam int FW   = 10;
    localparam int TMO  = 200;
    localparam int SS   = 2;
    localparam int HALF = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ps2_clk = 1'b1;
    logic            ps2_data = 1'b1;
    logic [NV*FW-1:0] voice_freq;
    logic [NV-1:0]   voice_active;
    logic            note_valid;
    logic            note_on;
    logic [FW-1:0]   note_freq;
    logic            frame_err;

    ps2_note_receiver #(
        .NUM_VOICES(NV), .FREQ_W(FW), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .voice_freq(voice_freq), .voice_active(voice_active),
        .note_valid(note_valid), .note_on(note_on), .note_freq(note_freq),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int strobe_cnt = 0, strobe_cyc = 0;
    int err_cnt = 0, err_cyc = 0;
    logic          last_on = 1'b0;
    logic [FW-1:0] last_freq = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (note_valid) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
            last_on    = note_on;
            last_freq  = note_freq;
        end
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    function automatic logic [FW-1:0] vf(input int i);
        return voice_freq[i*FW +: FW];
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; parity is odd unless par_flip is set.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_bit, input int nbits);
        logic [10:0] frm;
        frm = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(frm[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (voice_freq !== '0) begin n_bad++; $display("FAIL reset_voice_freq: got %h expected 0", voice_freq); end
        n_cmp++; if ({voice_active, note_valid, note_on, note_freq, frame_err} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: active=%b valid=%b on=%b freq=%0d err=%b expected all 0",
                              voice_active, note_valid, note_on, note_freq, frame_err); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (voice_active !== '0 || strobe_cnt !== 0 || err_cnt !== 0) begin
            n_bad++; $display("FAIL post_reset_quiet: active=%b strobes=%0d errs=%0d expected 0", voice_active, strobe_cnt, err_cnt); end
    endtask

    task automatic test_make_break;
        int s0;
        s0 = strobe_cnt;
        send_byte(8'h1C);
        n_cmp++; if (vf(0) !== 10'd261) begin n_bad++; $display("FAIL make_v0: got %0d expected 261", vf(0)); end
        n_cmp++; if (voice_active !== 4'b0001) begin n_bad++; $display("FAIL make_active: got %b expected 0001", voice_active); end
        n_cmp++; if (strobe_cnt !== s0 + 1 || last_on !== 1'b1 || last_freq !== 10'd261) begin
            n_bad++; $display("FAIL make_strobe: count=%0d on=%b freq=%0d expected %0d/1/261", strobe_cnt, last_on, last_freq, s0 + 1); end
        n_cmp++; if (strobe_cyc - fall_cyc !== SS + 3) begin
            n_bad++; $display("FAIL make_latency: got %0d expected %0d", strobe_cyc - fall_cyc, SS + 3); end
        send_byte(8'h1C);
        n_cmp++; if (strobe_cnt !== s0 + 1 || voice_active !== 4'b0001) begin
            n_bad++; $display("FAIL repeat_make: count=%0d active=%b expected %0d/0001", strobe_cnt, voice_active, s0 + 1); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++; if (vf(0) !== 10'd0 || voice_active !== 4'b0000) begin
            n_bad++; $display("FAIL break_clear: v0=%0d active=%b expected 0/0000", vf(0), voice_active); end
        n_cmp++; if (strobe_cnt !== s0 + 2 || last_on !== 1'b0 || last_freq !== 10'd261) begin
            n_bad++; $display("FAIL break_strobe: count=%0d on=%b freq=%0d expected %0d/0/261", strobe_cnt, last_on, last_freq, s0 + 2); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        n_cmp++; if (strobe_cnt !== s0 + 2) begin n_bad++; $display("FAIL break_unheld: count=%0d expected %0d", strobe_cnt, s0 + 2); end
    endtask

    task automatic test_polyphony;
        int s0;
        logic [7:0] codes [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        logic [7:0] rel   [4] = '{8'h1C, 8'h23, 8'h2B, 8'h34};
        s0 = strobe_cnt;
        foreach (codes[i]) send_byte(codes[i]);
        n_cmp++; if ({vf(3), vf(2), vf(1), vf(0)} !== {10'd349, 10'd329, 10'd293, 10'd261}) begin
            n_bad++; $display("FAIL poly_table: got %0d/%0d/%0d/%0d expected 261/293/329/349", vf(0), vf(1), vf(2), vf(3)); end
        n_cmp++; if (voice_active !== 4'b1111 || strobe_cnt !== s0 + 4) begin
            n_bad++; $display("FAIL poly_full_drop: active=%b count=%0d expected 1111/%0d", voice_active, strobe_cnt, s0 + 4); end
        send_byte(8'hF0);
        send_byte(8'h1B);
        n_cmp++; if (voice_active !== 4'b1101 || vf(1) !== 10'd0) begin
            n_bad++; $display("FAIL poly_break_v1: active=%b v1=%0d expected 1101/0", voice_active, vf(1)); end
        send_byte(8'h34);
        n_cmp++; if (vf(1) !== 10'd392 || voice_active !== 4'b1111) begin
            n_bad++; $display("FAIL poly_realloc: v1=%0d active=%b expected 392/1111", vf(1), voice_active); end
        foreach (rel[i]) begin send_byte(8'hF0); send_byte(rel[i]); end
        n_cmp++; if (voice_active !== 4'b0000 || strobe_cnt !== s0 + 10) begin
            n_bad++; $display("FAIL poly_release_all: active=%b count=%0d expected 0000/%0d", voice_active, strobe_cnt, s0 + 10); end
    endtask

    task automatic test_extended;
        int s0;
        s0 = strobe_cnt;
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'h15);
        n_cmp++; if (strobe_cnt !== s0 || voice_active !== 4'b0000) begin
            n_bad++; $display("FAIL ext_unmapped: count=%0d active=%b expected %0d/0000", strobe_cnt, voice_active, s0); end
        send_byte(8'h1C);
        n_cmp++; if (voice_active !== 4'b0001 || vf(0) !== 10'd261) begin
            n_bad++; $display("FAIL ext_flag_cleared: active=%b v0=%0d expected 0001/261", voice_active, vf(0)); end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_parity;
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
        n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL parity_err: got %0d expected %0d", err_cnt, e0 + 1); end
        n_cmp++; if (strobe_cnt !== s0 || voice_active !== 4'b0000) begin
            n_bad++; $display("FAIL parity_discard: count=%0d active=%b expected %0d/0000", strobe_cnt, voice_active, s0); end
`else
        n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL parity_ignored_err: got %0d expected %0d", err_cnt, e0); end
        n_cmp++; if (strobe_cnt !== s0 + 1 || vf(0) !== 10'd261) begin
            n_bad++; $display("FAIL parity_ignored_note: count=%0d v0=%0d expected %0d/261", strobe_cnt, vf(0), s0 + 1); end
        send_byte(8'hF0);
        send_byte(8'h1C);
`endif
    endtask

    task automatic test_stop_err;
        int s0, e0;
        send_byte(8'h33);
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_byte(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        n_cmp++; if (err_cnt !== e0 + 1 || strobe_cnt !== s0) begin
            n_bad++; $display("FAIL stop_err: errs=%0d count=%0d expected %0d/%0d", err_cnt, strobe_cnt, e0 + 1, s0); end
        n_cmp++; if (err_cyc - fall_cyc !== SS + 2) begin
            n_bad++; $display("FAIL stop_err_latency: got %0d expected %0d", err_cyc - fall_cyc, SS + 2); end
        send_byte(8'h33);
        n_cmp++; if (voice_active !== 4'b0000 || last_on !== 1'b0 || last_freq !== 10'd440) begin
            n_bad++; $display("FAIL brk_survives_err: active=%b on=%b freq=%0d expected 0000/0/440", voice_active, last_on, last_freq); end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 5);
        repeat (TMO + 50) @(negedge clk);
        n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL timeout_err: got %0d expected %0d", err_cnt, e0 + 1); end
        send_byte(8'h33);
        n_cmp++; if (vf(0) !== 10'd440 || voice_active !== 4'b0001) begin
            n_bad++; $display("FAIL timeout_recover: v0=%0d active=%b expected 440/0001", vf(0), voice_active); end
        send_byte(8'hF0);
        send_byte(8'h33);
    endtask

    task automatic test_reset_midframe;
        int s0;
        send_byte(8'h1C);
        send_byte(8'h1B);
        n_cmp++; if (voice_active !== 4'b0011) begin n_bad++; $display("FAIL pre_reset_held: got %b expected 0011", voice_active); end
        s0 = strobe_cnt;
        send_frame(8'h23, 1'b0, 1'b1, 9);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (voice_freq !== '0 || {voice_active, note_valid, note_on, note_freq, frame_err} !== '0) begin
            n_bad++; $display("FAIL midframe_reset: vf=%h active=%b valid=%b on=%b freq=%0d err=%b expected all 0",
                              voice_freq, voice_active, note_valid, note_on, note_freq, frame_err); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send_byte(8'h42);
        n_cmp++; if (vf(0) !== 10'd523 || voice_active !== 4'b0001 || strobe_cnt !== s0 + 1) begin
            n_bad++; $display("FAIL after_reset_frame: v0=%0d active=%b count=%0d expected 523/0001/%0d",
                              vf(0), voice_active, strobe_cnt, s0 + 1); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_polyphony();
        test_extended();
        test_parity();
        test_stop_err();
        test_timeout();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
